// File: rtl/bp_cce_inst_fetch_pkg.sv
// Shared types for the CCE instruction fetch stage: the FSM state enum and the
// microcode instruction word. Defines `BP_CCE_INST_ADDR_WIDTH if nothing else has.
`ifndef BP_CCE_INST_ADDR_WIDTH
`define BP_CCE_INST_ADDR_WIDTH 8
`endif

package bp_cce_inst_fetch_pkg;

  typedef enum logic [1:0] {
    e_reset = 2'd0,
    e_cfg   = 2'd1,
    e_boot  = 2'd2,
    e_fetch = 2'd3
  } bp_cce_inst_fetch_state_e;

  // The fields the pre-decoder needs for branch prediction sit alongside the opcode.
  typedef struct packed {
    logic [3:0]                           op;
    logic [3:0]                           minor_op;
    logic                                 branch;
    logic                                 predict_taken;
    logic [`BP_CCE_INST_ADDR_WIDTH-1:0]   branch_target;
    logic [13:0]                          imm;
  } bp_cce_inst_s;

endpackage

// File: rtl/bp_cce_inst_ram.sv
// Instruction RAM for the CCE fetch stage: one write port and one
// synchronous-read port. Contents are never reset.
module bp_cce_inst_ram #(
  parameter int width_p      = 32,
  parameter int els_p        = 256,
  parameter int addr_width_p = 8
) (
  input  logic                    clk_i,
  input  logic                    w_v_i,
  input  logic [addr_width_p-1:0] w_addr_i,
  input  logic [width_p-1:0]      w_data_i,
  input  logic [addr_width_p-1:0] r_addr_i,
  output logic [width_p-1:0]      r_data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem[w_addr_i] <= w_data_i;
    end
    r_data_o <= mem[r_addr_i];
  end

endmodule

// File: rtl/bp_cce_inst_fetch.sv
// CCE microcode fetch stage: owns the instruction RAM and the fetch PC.
// Optional performance counters are enabled with BP_CCE_INST_FETCH_PERF_EN.
module bp_cce_inst_fetch
  import bp_cce_inst_fetch_pkg::*;
#(
  parameter int width_p        = 8,
  parameter int inst_ram_els_p = 2**width_p
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               ucode_en_i,
  input  logic               cfg_w_v_i,
  input  logic [width_p-1:0] cfg_addr_i,
  input  bp_cce_inst_s       cfg_data_i,
  output logic               cfg_ready_o,
  output logic [width_p-1:0] fetch_pc_o,
  output bp_cce_inst_s       inst_o,
  output logic               inst_v_o,
  input  logic [width_p-1:0] predicted_next_pc_i,
  input  logic               stall_i,
  input  logic               mispredict_v_i,
  input  logic [width_p-1:0] mispredict_pc_i,
  output logic [31:0]        fetch_cnt_o,
  output logic [31:0]        redirect_cnt_o
);

  bp_cce_inst_fetch_state_e state_r;
  logic [width_p-1:0]       fetch_pc_r;
  logic                     inst_v_r;
  logic                     cfg_ready_r;
  logic [width_p-1:0]       next_pc;
  logic                     enter_cfg;
  logic [$bits(bp_cce_inst_s)-1:0] ram_data;

  // The RAM is addressed by next_pc so its read data lines up with fetch_pc_r,
  // which is what lets a redirect land without a bubble.
  always_comb begin
    next_pc = fetch_pc_r;
    if (state_r == e_boot) begin
      next_pc = '0;
    end else if (state_r == e_fetch) begin
      if (mispredict_v_i) begin
        next_pc = mispredict_pc_i;
      end else if (!stall_i) begin
        next_pc = predicted_next_pc_i;
      end
    end
  end

  assign enter_cfg = (state_r == e_reset) || ((state_r == e_fetch) && !ucode_en_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= e_reset;
      fetch_pc_r  <= '0;
      inst_v_r    <= 1'b0;
      cfg_ready_r <= 1'b0;
    end else begin
      case (state_r)
        e_reset: begin
          state_r     <= e_cfg;
          cfg_ready_r <= 1'b1;
        end
        e_cfg: begin
          if (ucode_en_i) begin
            state_r     <= e_boot;
            cfg_ready_r <= 1'b0;
          end
        end
        e_boot: begin
          state_r    <= e_fetch;
          fetch_pc_r <= next_pc;
          inst_v_r   <= 1'b1;
        end
        e_fetch: begin
          fetch_pc_r <= next_pc;
          if (!ucode_en_i) begin
            state_r     <= e_cfg;
            inst_v_r    <= 1'b0;
            cfg_ready_r <= 1'b1;
          end
        end
        default: state_r <= e_reset;
      endcase
    end
  end

  bp_cce_inst_ram #(
    .width_p      ($bits(bp_cce_inst_s)),
    .els_p        (inst_ram_els_p),
    .addr_width_p (width_p)
  ) inst_ram (
    .clk_i    (clk_i),
    .w_v_i    (cfg_w_v_i && (state_r == e_cfg)),
    .w_addr_i (cfg_addr_i),
    .w_data_i (cfg_data_i),
    .r_addr_i (next_pc),
    .r_data_o (ram_data)
  );

  assign inst_o      = bp_cce_inst_s'(ram_data);
  assign fetch_pc_o  = fetch_pc_r;
  assign inst_v_o    = inst_v_r;
  assign cfg_ready_o = cfg_ready_r;

`ifdef BP_CCE_INST_FETCH_PERF_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] redirect_cnt_r;

  // Both counters saturate and restart every time the engine drops back to config.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fetch_cnt_r    <= '0;
      redirect_cnt_r <= '0;
    end else if (enter_cfg) begin
      fetch_cnt_r    <= '0;
      redirect_cnt_r <= '0;
    end else begin
      if (inst_v_r && !stall_i && !mispredict_v_i && !(&fetch_cnt_r)) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end
      if ((state_r == e_fetch) && mispredict_v_i && !(&redirect_cnt_r)) begin
        redirect_cnt_r <= redirect_cnt_r + 32'd1;
      end
    end
  end

  assign fetch_cnt_o    = fetch_cnt_r;
  assign redirect_cnt_o = redirect_cnt_r;
`else
  assign fetch_cnt_o    = 32'd0;
  assign redirect_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_bp_cce_inst_fetch.sv
// Self-checking bench for bp_cce_inst_fetch: directed test-plan scenarios with
// literal expectations, then randomized traffic checked by a behavioural model.
module tb_bp_cce_inst_fetch;
  import bp_cce_inst_fetch_pkg::*;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         ucode_en_i;
  logic         cfg_w_v_i;
  logic [7:0]   cfg_addr_i;
  bp_cce_inst_s cfg_data_i;
  logic         cfg_ready_o;
  logic [7:0]   fetch_pc_o;
  bp_cce_inst_s inst_o;
  logic         inst_v_o;
  logic [7:0]   predicted_next_pc_i;
  logic         stall_i;
  logic         mispredict_v_i;
  logic [7:0]   mispredict_pc_i;
  logic [31:0]  fetch_cnt_o;
  logic [31:0]  redirect_cnt_o;

  int total = 0;
  int bad   = 0;

  bp_cce_inst_s data_tbl [256];

  bp_cce_inst_fetch dut (
    .clk_i               (clk_i),
    .reset_n_i           (reset_n_i),
    .ucode_en_i          (ucode_en_i),
    .cfg_w_v_i           (cfg_w_v_i),
    .cfg_addr_i          (cfg_addr_i),
    .cfg_data_i          (cfg_data_i),
    .cfg_ready_o         (cfg_ready_o),
    .fetch_pc_o          (fetch_pc_o),
    .inst_o              (inst_o),
    .inst_v_o            (inst_v_o),
    .predicted_next_pc_i (predicted_next_pc_i),
    .stall_i             (stall_i),
    .mispredict_v_i      (mispredict_v_i),
    .mispredict_pc_i     (mispredict_pc_i),
    .fetch_cnt_o         (fetch_cnt_o),
    .redirect_cnt_o      (redirect_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs at the negedge; the pre-decoder is emulated from
  // the current fetch outputs unless a random prediction is requested.
  task automatic applyStimulus(input logic ucode, input logic w_v, input logic [7:0] w_addr,
                               input bp_cce_inst_s w_data, input logic stall, input logic mp_v,
                               input logic [7:0] mp_pc, input logic rand_pred);
    bp_cce_inst_s cur;
    @(negedge clk_i);
    cur = inst_o;
    ucode_en_i      = ucode;
    cfg_w_v_i       = w_v;
    cfg_addr_i      = w_addr;
    cfg_data_i      = w_data;
    stall_i         = stall;
    mispredict_v_i  = mp_v;
    mispredict_pc_i = mp_pc;
    if (rand_pred) predicted_next_pc_i = 8'($urandom);
    else if (cur.branch && cur.predict_taken) predicted_next_pc_i = cur.branch_target;
    else predicted_next_pc_i = fetch_pc_o + 8'd1;
  endtask

  task automatic run_cycle(input logic ucode, input logic stall, input logic mp_v, input logic [7:0] mp_pc);
    applyStimulus(ucode, 1'b0, 8'd0, '0, stall, mp_v, mp_pc, 1'b0);
    @(posedge clk_i);
    #3;
  endtask

  task automatic expect_fetch(input string name, input logic [7:0] pc, input bp_cce_inst_s inst);
    checkOutput({name, "_v"}, 32'(inst_v_o), 32'd1);
    checkOutput({name, "_pc"}, 32'(fetch_pc_o), 32'(pc));
    checkOutput({name, "_inst"}, 32'(inst_o), 32'(inst));
  endtask

  // Behavioural model: engine mode, expected PC/valid/ready and the microcode
  // image, advanced from the inputs seen at each rising edge.
  int           m_mode = 0;
  logic         m_v = 1'b0;
  logic         m_ready = 1'b0;
  logic [7:0]   m_pc = 8'd0;
  logic [31:0]  m_fcnt = 32'd0;
  logic [31:0]  m_rcnt = 32'd0;
  bp_cce_inst_s m_mem [256];

  always @(posedge clk_i) begin
    if (!reset_n_i) begin
      m_mode = 0; m_v = 1'b0; m_ready = 1'b0; m_pc = 8'd0; m_fcnt = 32'd0; m_rcnt = 32'd0;
    end else begin
      case (m_mode)
        0: begin
          m_mode = 1; m_ready = 1'b1; m_fcnt = 32'd0; m_rcnt = 32'd0;
        end
        1: begin
          if (cfg_w_v_i) m_mem[cfg_addr_i] = cfg_data_i;
          if (ucode_en_i) begin m_mode = 2; m_ready = 1'b0; end
        end
        2: begin
          m_mode = 3; m_pc = 8'd0; m_v = 1'b1;
        end
        default: begin
          if (m_v && !stall_i && !mispredict_v_i && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 32'd1;
          if (mispredict_v_i && m_rcnt != 32'hFFFF_FFFF) m_rcnt = m_rcnt + 32'd1;
          if (mispredict_v_i) m_pc = mispredict_pc_i;
          else if (!stall_i) m_pc = predicted_next_pc_i;
          if (!ucode_en_i) begin
            m_mode = 1; m_v = 1'b0; m_ready = 1'b1; m_fcnt = 32'd0; m_rcnt = 32'd0;
          end
        end
      endcase
    end
    #2;
    checkOutput("m_inst_v", 32'(inst_v_o), 32'(m_v));
    checkOutput("m_cfg_ready", 32'(cfg_ready_o), 32'(m_ready));
    if (m_v) begin
      checkOutput("m_fetch_pc", 32'(fetch_pc_o), 32'(m_pc));
      checkOutput("m_inst", 32'(inst_o), 32'(m_mem[m_pc]));
    end
`ifdef BP_CCE_INST_FETCH_PERF_EN
    checkOutput("m_fetch_cnt", fetch_cnt_o, m_fcnt);
    checkOutput("m_redirect_cnt", redirect_cnt_o, m_rcnt);
`else
    checkOutput("m_fetch_cnt", fetch_cnt_o, 32'd0);
    checkOutput("m_redirect_cnt", redirect_cnt_o, 32'd0);
`endif
  end

  initial begin
    bp_cce_inst_s i0, i1, i2, i1b, poison, d;
    i0 = 32'h1100_0001;
    i1 = 32'h1200_0002;
    i2 = 32'h1300_0003;
    i1b = '0;
    i1b.op = 4'h7; i1b.branch = 1'b1; i1b.predict_taken = 1'b1; i1b.branch_target = 8'h05;
    poison = 32'hDEAD_BEEF;

    reset_n_i = 1'b0; ucode_en_i = 1'b0; cfg_w_v_i = 1'b0; cfg_addr_i = 8'd0; cfg_data_i = '0;
    predicted_next_pc_i = 8'd0; stall_i = 1'b0; mispredict_v_i = 1'b0; mispredict_pc_i = 8'd0;

    repeat (2) @(posedge clk_i);
    #3;
    checkOutput("rst_inst_v", 32'(inst_v_o), 32'd0);
    checkOutput("rst_cfg_ready", 32'(cfg_ready_o), 32'd0);
    checkOutput("rst_fetch_pc", 32'(fetch_pc_o), 32'd0);

    @(negedge clk_i) reset_n_i = 1'b1;
    @(posedge clk_i);
    #3;
    checkOutput("cfg_ready_up", 32'(cfg_ready_o), 32'd1);

    // Fill the whole image; filler words never predict taken.
    for (int a = 0; a < 256; a++) begin
      d = bp_cce_inst_s'($urandom);
      d.branch = 1'b0; d.predict_taken = 1'b0;
      if (a == 0) d = i0;
      if (a == 1) d = i1;
      if (a == 2) d = i2;
      data_tbl[a] = d;
      applyStimulus(1'b0, 1'b1, 8'(a), d, 1'b0, 1'b0, 8'd0, 1'b0);
    end

    // Boot: two cycles of latency, then sequential fetch 0,1,2.
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("boot_inst_v", 32'(inst_v_o), 32'd0);
    checkOutput("boot_cfg_ready", 32'(cfg_ready_o), 32'd0);
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0); expect_fetch("seq0", 8'h00, i0);
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0); expect_fetch("seq1", 8'h01, i1);
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0); expect_fetch("seq2", 8'h02, i2);
    for (int s = 0; s < 3; s++) begin
      run_cycle(1'b1, 1'b1, 1'b0, 8'd0); expect_fetch("stall_hold", 8'h02, i2);
    end
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0); expect_fetch("after_stall", 8'h03, data_tbl[3]);
    run_cycle(1'b1, 1'b1, 1'b1, 8'h10); expect_fetch("mp_over_stall", 8'h10, data_tbl[16]);

    run_cycle(1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("exit_inst_v", 32'(inst_v_o), 32'd0);
    checkOutput("exit_cfg_ready", 32'(cfg_ready_o), 32'd1);

    // Predicted-taken branch at PC 1 jumps to 5 without a bubble.
    applyStimulus(1'b0, 1'b1, 8'd1, i1b, 1'b0, 1'b0, 8'd0, 1'b0);
    data_tbl[1] = i1b;
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0);
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0); expect_fetch("br0", 8'h00, i0);
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0); expect_fetch("br1", 8'h01, i1b);
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0); expect_fetch("br5", 8'h05, data_tbl[5]);
`ifdef BP_CCE_INST_FETCH_PERF_EN
    checkOutput("fetch_cnt_lit", fetch_cnt_o, 32'd2);
`endif

    // Redirect near the top of the PC space and wrap through 0xFF.
    run_cycle(1'b1, 1'b0, 1'b1, 8'hFE); expect_fetch("wrap_fe", 8'hFE, data_tbl[254]);
`ifdef BP_CCE_INST_FETCH_PERF_EN
    checkOutput("fetch_cnt_mp", fetch_cnt_o, 32'd2);
    checkOutput("redirect_cnt_lit", redirect_cnt_o, 32'd1);
`endif
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0); expect_fetch("wrap_ff", 8'hFF, data_tbl[255]);
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0); expect_fetch("wrap_00", 8'h00, i0);

    // A write while fetching must not land in the RAM.
    applyStimulus(1'b1, 1'b1, 8'h20, poison, 1'b0, 1'b0, 8'd0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 8'd0);
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0);
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0); expect_fetch("reboot0", 8'h00, i0);
    run_cycle(1'b1, 1'b0, 1'b1, 8'h20); expect_fetch("no_write_in_fetch", 8'h20, data_tbl[32]);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 800; n++) begin
      applyStimulus(($urandom % 16) != 0, ($urandom % 3) == 0, 8'($urandom),
                    bp_cce_inst_s'($urandom), ($urandom % 4) == 0, ($urandom % 8) == 0,
                    8'($urandom), ($urandom % 2) == 0);
    end

    // Asynchronous reset in the middle of a fetch cycle.
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0);
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0);
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0);
    run_cycle(1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("pre_areset_v", 32'(inst_v_o), 32'd1);
    #1 reset_n_i = 1'b0;
    #1;
    checkOutput("areset_inst_v", 32'(inst_v_o), 32'd0);
    checkOutput("areset_fetch_pc", 32'(fetch_pc_o), 32'd0);
    checkOutput("areset_cfg_ready", 32'(cfg_ready_o), 32'd0);
    checkOutput("areset_fetch_cnt", fetch_cnt_o, 32'd0);
    checkOutput("areset_redirect_cnt", redirect_cnt_o, 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) reset_n_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #3;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_cce_inst_fetch.md
Name: bp_cce_inst_fetch

Overview:
- Fetch stage of the CCE microcode engine: owns the instruction RAM and the fetch PC register.
- Drives the registered fetch PC and the raw RAM read to the pre-decoder, and registers the pre-decoder's predicted next PC back into the fetch PC.
- Muxes in mispredict redirects and stalls from the decode/execute stage, and accepts microcode writes while the engine is in config mode.

Parameters:
- width_p, 8, fetch PC / instruction RAM address width; must be <= `bp_cce_inst_addr_width.
- inst_ram_els_p, 2**width_p, instruction RAM depth.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- ucode_en_i  in  1  1 = run microcode, 0 = config mode
- cfg_w_v_i  in  1  microcode write valid (honoured only in e_cfg)
- cfg_addr_i  in  width_p  microcode write address
- cfg_data_i  in  $bits(bp_cce_inst_s)  microcode write data
- cfg_ready_o  out  1  1 while in e_cfg
- fetch_pc_o  out  width_p  registered fetch PC; feeds the pre-decoder pc_i
- inst_o  out  bp_cce_inst_s  RAM read data for fetch_pc_o; feeds pre-decoder and decode
- inst_v_o  out  1  inst_o/fetch_pc_o valid
- predicted_next_pc_i  in  width_p  pre-decoder result for fetch_pc_o
- stall_i  in  1  decode cannot accept inst_o this cycle
- mispredict_v_i  in  1  redirect request
- mispredict_pc_i  in  width_p  redirect target

Behaviour:
- Reset (async assert, sync deassert use): state=e_reset, fetch_pc_o=0, inst_v_o=0, cfg_ready_o=0.
- Instruction RAM: 1 read port, 1 write port, synchronous read. The RAM read address is next_pc (combinational), so data for fetch_pc_o appears one cycle after the address is presented, aligned with the fetch PC register.
- FSM:
  - e_reset: always -> e_cfg.
  - e_cfg: cfg_ready_o=1, inst_v_o=0; cfg_w_v_i writes cfg_data_i to cfg_addr_i in the same cycle. When ucode_en_i=1, go to e_boot. A simultaneous cfg_w_v_i in that cycle is still written.
  - e_boot: present address 0 to the RAM, fetch_pc<=0 -> e_fetch. inst_v_o=0 in this state.
  - e_fetch: inst_v_o=1 unless squashed. next_pc priority:
    - mispredict_v_i -> mispredict_pc_i
    - else stall_i -> fetch_pc (re-read the same address, hold outputs)
    - else predicted_next_pc_i
  - fetch_pc<=next_pc every cycle in e_fetch.
- Mispredict: the cycle after mispredict_v_i, fetch_pc_o=mispredict_pc_i and inst_v_o=1 with the new instruction; there is no bubble because the RAM read was issued from next_pc. mispredict_v_i overrides a simultaneous stall_i.
- Stall: inst_o and fetch_pc_o hold stable for every cycle stall_i=1. Upstream drops stall_i to consume.
- ucode_en_i falling in e_fetch: next cycle state=e_cfg and inst_v_o=0; any in-flight instruction is dropped.
- cfg_w_v_i outside e_cfg is ignored; the RAM is not written.
- Wrap-around: PC arithmetic is width_p bits and wraps (0xFF+1=0x00 at width_p=8). No special handling is required because the pre-decoder supplies the wrapped value.
- Latency: ucode_en_i rise -> first inst_v_o = 2 cycles (e_cfg -> e_boot -> e_fetch).
- Reset mid-operation: asynchronous return to reset values. RAM contents are not cleared.

Optional Feature:
- BP_CCE_INST_FETCH_PERF_EN.
- Defined: two 32-bit saturating counters, fetch_cnt_o (increments on inst_v_o & ~stall_i & ~mispredict_v_i) and redirect_cnt_o (increments on mispredict_v_i in e_fetch). Both clear on reset and on entry to e_cfg.
- Undefined: both ports exist but are tied to 0; no counter flops.

Decomposition:
- bp_me_pkg: bp_cce_inst_fetch_state_e {e_reset, e_cfg, e_boot, e_fetch}. bp_cce_inst_s and `bp_cce_inst_addr_width are reused from there.
- Sub-module: bp_cce_inst_ram, a 1R1W synchronous-read RAM wrapping bsg_mem_1r1w_sync of width $bits(bp_cce_inst_s) and depth inst_ram_els_p.

Test Plan:
- Config and boot: write addr0=I0, addr1=I1, addr2=I2 in e_cfg, raise ucode_en_i, loop predicted_next_pc_i=fetch_pc_o+1 -> inst_v_o rises 2 cycles later with fetch_pc_o=0, inst_o=I0, then PC 1 (I1), then PC 2 (I2).
- Predicted-taken branch: I1 with branch=1, predict_taken=1, target=5; predecode gives 5 -> fetch_pc_o sequence 0,1,5 with no bubbles.
- Stall: assert stall_i for 3 cycles at PC 2 -> fetch_pc_o=2 and inst_o=I2 held for 4 cycles total, then PC 3.
- Mispredict with simultaneous stall: mispredict_v_i=1, mispredict_pc_i=0x10, stall_i=1 at PC 3 -> next cycle fetch_pc_o=0x10, inst_v_o=1, inst_o=mem[0x10].
- Wrap and mode exit: PC 0xFF with sequential prediction -> next PC 0x00. Drop ucode_en_i -> inst_v_o=0 and cfg_ready_o=1 next cycle. A cfg_w_v_i issued during e_fetch is not written; check mem readback.
- Async reset mid-fetch: pull reset_n_i low between clock edges -> inst_v_o=0 and fetch_pc_o=0 immediately; with BP_CCE_INST_FETCH_PERF_EN defined, counters read 0.
